seq_div8x4: RTL and testbench

Sequential unsigned divider, the inverse of the team's 4x4 array multiplier: takes an 8-bit dividend and a 4-bit divisor and returns an 8-bit quotient and 4-bit remainder by restoring division, one quotient bit per clock. It sits beside the multiplier in the arithmetic datapath of the course project. A start/busy/done handshake lets a controller issue back-to-back operations. It also lets the bench cross-check results against the multiplier (quotient × divisor + remainder = dividend).

---
 rtl/seq_div8x4_pkg.sv | 28 ++
 rtl/seq_div8x4_step.sv | 32 +++
 rtl/seq_div8x4.sv | 128 ++++++++++++
 tb/tb_seq_div8x4.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_div8x4_pkg.sv
// ---------------------------------------------------------------------------
// seq_div8x4_pkg
// Shared constants and types for the sequential 8/4 restoring divider.
//   DVD_W  dividend / quotient width
//   DVS_W  divisor / remainder width
//   ITER   quotient bits produced, one per CALC cycle
//   state_e  controller states
// ---------------------------------------------------------------------------
package seq_div8x4_pkg;

  localparam int DVD_W = 8;
  localparam int DVS_W = 4;
  localparam int ITER  = 8;
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Last iteration index; CALC exits to DONE when the counter reaches it.
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);

  // Quotient reported for a zero divisor.
  localparam logic [DVD_W-1:0] DBZ_QUO = '1;

endpackage

// File: rtl/seq_div8x4_step.sv
// ---------------------------------------------------------------------------
// seq_div8x4_step (div_step)
// One restoring-division iteration, purely combinational.
//   rem_i  in  4  partial remainder (always < divisor)
//   bit_i  in  1  next dividend bit, MSB first
//   dvs_i  in  4  divisor
//   rem_o  out 4  next partial remainder
//   q_o    out 1  quotient bit for this iteration
// ---------------------------------------------------------------------------
module div_step
  import seq_div8x4_pkg::*;
(
  input  logic [DVS_W-1:0] rem_i,
  input  logic             bit_i,
  input  logic [DVS_W-1:0] dvs_i,
  output logic [DVS_W-1:0] rem_o,
  output logic             q_o
);

  logic [DVS_W:0] trial;
  logic [DVS_W:0] dvs_ext;

  always_comb begin
    trial   = {rem_i, bit_i};
    dvs_ext = {1'b0, dvs_i};
    q_o     = (trial >= dvs_ext);
    // When the subtract succeeds the difference is below the divisor,
    // so dropping the top bit loses nothing.
    rem_o   = q_o ? DVS_W'(trial - dvs_ext) : trial[DVS_W-1:0];
  end

endmodule

// File: rtl/seq_div8x4.sv
// ---------------------------------------------------------------------------
// seq_div8x4
// Sequential unsigned restoring divider: 8-bit dividend / 4-bit divisor,
// one quotient bit per clock, start/busy/done handshake.
//   clk        in  1  rising-edge clock
//   rst        in  1  synchronous active-high reset
//   start      in  1  request, sampled only while busy=0
//   dividend   in  8  captured on an accepted start
//   divisor    in  4  captured on an accepted start
//   busy       out 1  operation in progress
//   done       out 1  one-cycle pulse, results valid
//   quotient   out 8  held until the next accepted start
//   remainder  out 4  held until the next accepted start
//   dbz        out 1  last result was a divide by zero
// ---------------------------------------------------------------------------
module seq_div8x4
  import seq_div8x4_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             dbz
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DVD_W-1:0]   dvd_q,   dvd_d;    // dividend, shifted left each CALC
  logic [DVS_W-1:0]   dvs_q,   dvs_d;
  logic [DVD_W-1:0]   quo_q,   quo_d;
  logic [DVS_W-1:0]   rem_q,   rem_d;    // partial remainder, final remainder
  logic               dbz_q,   dbz_d;
  // A zero-divisor request spends one idle cycle before DONE so that its
  // done pulse arrives one cycle after acceptance with busy kept low.
  logic               zpend_q, zpend_d;

  logic [DVS_W-1:0]   step_rem;
  logic               step_q;

  div_step u_step (
    .rem_i (rem_q),
    .bit_i (dvd_q[DVD_W-1]),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    zpend_d = zpend_q;

    unique case (state_q)
      ST_CALC: begin
        dvd_d   = dvd_q << 1;
        rem_d   = step_rem;
        quo_d   = {quo_q[DVD_W-2:0], step_q};
        count_d = count_q + 1'b1;
        if (count_q == LAST_ITER) state_d = ST_DONE;
      end
      ST_IDLE, ST_DONE: begin
        if (zpend_q) begin
          // Operands were already captured; a start here is not taken.
          zpend_d = 1'b0;
          state_d = ST_DONE;
        end else if (start) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          count_d = '0;
          dbz_d   = 1'b0;
          if (divisor != '0) begin
            rem_d   = '0;
            quo_d   = '0;
            state_d = ST_CALC;
          end else begin
            quo_d   = DBZ_QUO;
            rem_d   = dividend[DVS_W-1:0];
            dbz_d   = 1'b1;
            zpend_d = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      zpend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      zpend_q <= zpend_d;
    end
  end

  assign busy      = (state_q == ST_CALC);
  assign done      = (state_q == ST_DONE);
  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign dbz       = dbz_q;

endmodule

// File: tb/tb_seq_div8x4.sv
// ---------------------------------------------------------------------------
// tb_seq_div8x4
// Directed self-checking bench for seq_div8x4.
// ---------------------------------------------------------------------------
module tb_seq_div8x4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy, done, dbz;
  logic [7:0] quotient;
  logic [3:0] remainder;

  int n_chk  = 0;
  int n_fail = 0;

  seq_div8x4 dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz)
  );

  always #5 clk = ~clk;

  // Present one start for exactly one edge; returns 1 time unit after it.
  task automatic start_op(input logic [7:0] a, input logic [3:0] b);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
  endtask

  // Count edges until done; lat=99 if it never arrives within the bound.
  task automatic wait_done(output int lat, output logic saw_busy,
                           output logic [7:0] q, output logic [3:0] r,
                           output logic z);
    bit got = 0;
    lat = 0; saw_busy = 1'b0;
    while (!got && lat < 20) begin
      if (busy) saw_busy = 1'b1;
      @(posedge clk);
      lat++;
      #1;
      if (done) got = 1;
    end
    if (!got) lat = 99;
    q = quotient; r = remainder; z = dbz;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; dividend = 8'd0; divisor = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({busy, done, quotient, remainder, dbz} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b q=%0d r=%0d dbz=%b want all 0",
               busy, done, quotient, remainder, dbz);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int lat; logic sb; logic [7:0] q; logic [3:0] r; logic z;
    start_op(8'd200, 4'd7);
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL basic_busy_after_start: got %b want 1", busy);
    end
    wait_done(lat, sb, q, r, z);
    n_chk++;
    if (lat !== 8) begin n_fail++; $display("FAIL basic_latency: got %0d want 8", lat); end
    n_chk++;
    if (q !== 8'd28 || r !== 4'd4 || z !== 1'b0) begin
      n_fail++; $display("FAIL basic_200_7: got q=%0d r=%0d dbz=%b want 28 4 0", q, r, z);
    end
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done: got %b want 0", busy); end
    @(posedge clk); #1;
    n_chk++;
    if (done !== 1'b0 || quotient !== 8'd28 || remainder !== 4'd4) begin
      n_fail++;
      $display("FAIL basic_done_pulse_hold: got done=%b q=%0d r=%0d want 0 28 4",
               done, quotient, remainder);
    end
    start_op(8'd255, 4'd1);
    wait_done(lat, sb, q, r, z);
    n_chk++;
    if (lat !== 8 || q !== 8'd255 || r !== 4'd0) begin
      n_fail++; $display("FAIL basic_255_1: got lat=%0d q=%0d r=%0d want 8 255 0", lat, q, r);
    end
  endtask

  task automatic test_small;
    int lat; logic sb; logic [7:0] q; logic [3:0] r; logic z;
    start_op(8'd5, 4'd9);
    wait_done(lat, sb, q, r, z);
    n_chk++;
    if (lat !== 8 || q !== 8'd0 || r !== 4'd5) begin
      n_fail++; $display("FAIL small_5_9: got lat=%0d q=%0d r=%0d want 8 0 5", lat, q, r);
    end
    start_op(8'd15, 4'd15);
    wait_done(lat, sb, q, r, z);
    n_chk++;
    if (lat !== 8 || q !== 8'd1 || r !== 4'd0) begin
      n_fail++; $display("FAIL small_15_15: got lat=%0d q=%0d r=%0d want 8 1 0", lat, q, r);
    end
  endtask

  task automatic test_dbz;
    int lat; logic sb; logic [7:0] q; logic [3:0] r; logic z;
    start_op(8'h83, 4'd0);
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL dbz_after_accept: got busy=%b done=%b want 0 0", busy, done);
    end
    wait_done(lat, sb, q, r, z);
    n_chk++;
    if (lat !== 1) begin n_fail++; $display("FAIL dbz_latency: got %0d want 1", lat); end
    n_chk++;
    if (sb !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL dbz_busy: got saw_busy=%b busy=%b want 0 0", sb, busy);
    end
    n_chk++;
    if (q !== 8'hFF || r !== 4'd3 || z !== 1'b1) begin
      n_fail++; $display("FAIL dbz_result: got q=%h r=%0d dbz=%b want ff 3 1", q, r, z);
    end
    start_op(8'd10, 4'd3);
    wait_done(lat, sb, q, r, z);
    n_chk++;
    if (lat !== 8 || q !== 8'd3 || r !== 4'd1 || z !== 1'b0) begin
      n_fail++;
      $display("FAIL dbz_followup_10_3: got lat=%0d q=%0d r=%0d dbz=%b want 8 3 1 0", lat, q, r, z);
    end
  endtask

  task automatic test_ignore_and_back_to_back;
    int lat; logic sb; logic [7:0] q; logic [3:0] r; logic z;
    bit got;
    start_op(8'd100, 4'd3);
    lat = 0; got = 0;
    while (!got && lat < 20) begin
      @(negedge clk);
      if (lat >= 2 && lat <= 4) begin
        start = 1'b1; dividend = 8'd50; divisor = 4'd5;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      lat++;
      #1;
      if (done) got = 1;
    end
    start = 1'b0;
    if (!got) lat = 99;
    n_chk++;
    if (lat !== 8 || quotient !== 8'd33 || remainder !== 4'd1) begin
      n_fail++;
      $display("FAIL ignore_start_100_3: got lat=%0d q=%0d r=%0d want 8 33 1",
               lat, quotient, remainder);
    end
    // Next start lands in the DONE cycle.
    start_op(8'd77, 4'd6);
    n_chk++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL b2b_accept: got busy=%b done=%b want 1 0", busy, done);
    end
    wait_done(lat, sb, q, r, z);
    n_chk++;
    if (lat !== 8 || q !== 8'd12 || r !== 4'd5) begin
      n_fail++; $display("FAIL b2b_77_6: got lat=%0d q=%0d r=%0d want 8 12 5", lat, q, r);
    end
  endtask

  task automatic test_reset_mid;
    int lat; logic sb; logic [7:0] q; logic [3:0] r; logic z;
    int spurious = 0;
    start_op(8'd200, 4'd7);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if ({busy, done, quotient, remainder, dbz} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got busy=%b done=%b q=%0d r=%0d dbz=%b want all 0",
               busy, done, quotient, remainder, dbz);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done || busy) spurious++;
    end
    n_chk++;
    if (spurious !== 0) begin
      n_fail++; $display("FAIL reset_mid_no_done: got %0d active cycles want 0", spurious);
    end
    start_op(8'd9, 4'd2);
    wait_done(lat, sb, q, r, z);
    n_chk++;
    if (lat !== 8 || q !== 8'd4 || r !== 4'd1) begin
      n_fail++; $display("FAIL reset_mid_9_2: got lat=%0d q=%0d r=%0d want 8 4 1", lat, q, r);
    end
  endtask

  task automatic test_sweep;
    int lat; logic sb; logic [7:0] q; logic [3:0] r; logic z;
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        start_op(8'(a), 4'(b));
        wait_done(lat, sb, q, r, z);
        n_chk++;
        if (lat !== 8 || (int'(q) * b + int'(r)) !== a || int'(r) >= b || z !== 1'b0) begin
          n_fail++;
          $display("FAIL sweep_identity %0d/%0d: got lat=%0d q=%0d r=%0d dbz=%b", a, b, lat, q, r, z);
        end
        n_chk++;
        if (int'(q) !== a / b) begin
          n_fail++; $display("FAIL sweep_quotient %0d/%0d: got %0d want %0d", a, b, q, a / b);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_small();
    test_dbz();
    test_ignore_and_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
